systolic_output_drain: RTL and testbench

Downstream stage of `systolic_array`. It captures the full `ROWS x COLS` accumulator matrix when the array signals `compute_done`. It then requantises each element: arithmetic right shift followed by signed saturation to `OUT_WIDTH`. Finally it streams the result one row per valid/ready handshake to the writeback path, which frees the array to start the next tile while the drain is still streaming.

---
 rtl/systolic_output_drain_if.sv | 26 ++
 rtl/systolic_output_drain.sv | 132 +++++++++++++
 tb/tb_systolic_output_drain.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_output_drain_if.sv
// Row stream from the drain to writeback: one requantised row per valid/ready beat.
// A beat transfers on a rising clk edge where out_valid & out_ready; the master holds every out_* signal stable while out_valid & ~out_ready.
interface systolic_output_drain_if #(
    parameter int ROWS      = 64,
    parameter int COLS      = 64,
    parameter int OUT_WIDTH = 32
) ();
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

    logic                      out_valid;
    logic                      out_ready;
    logic [COLS*OUT_WIDTH-1:0] out_row;
    logic [RW-1:0]             out_row_idx;
    logic                      out_last;
    logic                      out_sat;

    modport master (
        output out_valid, out_row, out_row_idx, out_last, out_sat,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_row, out_row_idx, out_last, out_sat,
        output out_ready
    );
endinterface

// File: rtl/systolic_output_drain.sv
// Captures the array's accumulator matrix on a compute_done rising edge, then streams it
// one requantised row per beat (arithmetic shift + signed saturation) while the array runs on.
module systolic_output_drain #(
    parameter int ROWS      = 64,
    parameter int COLS      = 64,
    parameter int OP_WIDTH  = 48,
    parameter int OUT_WIDTH = 32,
    parameter int SHIFT     = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          compute_done,
    input  logic [ROWS*COLS*OP_WIDTH-1:0] output_matrix,
    input  logic [31:0]                   cycles_count,
    systolic_output_drain_if.master       drain,
    output logic                          busy,
    output logic                          frame_done,
    output logic [31:0]                   frame_cycles,
    output logic [31:0]                   sat_count,
    output logic                          drop_err
);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int RB = COLS * OP_WIDTH;
    localparam int PW = $clog2(COLS + 1);

    typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;

    state_t                    state;
    state_t                    state_nx;
    logic                      done_q;
    logic                      armed;
    logic                      cap_ev;
    logic                      hs;
    logic                      last_row;
    logic                      fin;
    logic                      capture;
    logic [RW-1:0]             row_cnt;
    logic [RB-1:0]             frame_buf [ROWS];
    logic [RB-1:0]             row_data;
    logic signed [OP_WIDTH-1:0] s;
    logic [COLS*OUT_WIDTH-1:0] req_row;
    logic [COLS-1:0]           sat_flags;
    logic [PW-1:0]             sat_pop;

    // armed needs compute_done seen low after reset, so a level held across reset never recaptures.
    assign cap_ev   = compute_done & ~done_q & armed;
    assign hs       = (state == STREAM) & drain.out_ready;
    assign last_row = (row_cnt == RW'(ROWS - 1));
    assign fin      = hs & last_row;
    assign capture  = cap_ev & ((state == IDLE) | fin);
    assign row_data = frame_buf[row_cnt];

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (cap_ev) state_nx = STREAM;
            STREAM:  if (fin && !cap_ev) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        drain.out_valid   = (state == STREAM);
        busy              = (state == STREAM);
        drain.out_row     = '0;
        drain.out_row_idx = '0;
        drain.out_last    = 1'b0;
        drain.out_sat     = 1'b0;
        if (state == STREAM) begin
            drain.out_row     = req_row;
            drain.out_row_idx = row_cnt;
            drain.out_last    = last_row;
            drain.out_sat     = |sat_flags;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            done_q       <= 1'b0;
            armed        <= 1'b0;
            row_cnt      <= '0;
            sat_count    <= '0;
            frame_cycles <= '0;
            frame_done   <= 1'b0;
            drop_err     <= 1'b0;
        end else begin
            done_q     <= compute_done;
            armed      <= armed | ~compute_done;
            frame_done <= fin;
            if (cap_ev && !capture) drop_err <= 1'b1;
            if (capture) begin
                row_cnt      <= '0;
                sat_count    <= '0;
                frame_cycles <= cycles_count;
            end else if (hs) begin
                sat_count <= sat_count + 32'(sat_pop);
                if (!last_row) row_cnt <= row_cnt + 1'b1;
            end
        end
    end

    // Frame storage carries no reset: outputs are masked outside STREAM.
    always_ff @(posedge clk) begin
        if (capture) begin
            for (int r = 0; r < ROWS; r++) frame_buf[r] <= output_matrix[r*RB +: RB];
        end
    end

    // Saturate when the bits above the output sign bit are not all copies of it.
    always_comb begin
        s         = '0;
        req_row   = '0;
        sat_flags = '0;
        sat_pop   = '0;
        for (int c = 0; c < COLS; c++) begin
            s = $signed(row_data[c*OP_WIDTH +: OP_WIDTH]) >>> SHIFT;
            if ((&s[OP_WIDTH-1:OUT_WIDTH-1]) || !(|s[OP_WIDTH-1:OUT_WIDTH-1])) begin
                req_row[c*OUT_WIDTH +: OUT_WIDTH] = s[OUT_WIDTH-1:0];
            end else begin
                sat_flags[c] = 1'b1;
                req_row[c*OUT_WIDTH +: OUT_WIDTH] = s[OP_WIDTH-1] ?
                    {1'b1, {(OUT_WIDTH-1){1'b0}}} : {1'b0, {(OUT_WIDTH-1){1'b1}}};
            end
            sat_pop = sat_pop + PW'(sat_flags[c]);
        end
    end
endmodule

// File: tb/tb_systolic_output_drain.sv
// Bench for systolic_output_drain: random frames and ready patterns against a queue-based
// frame model, plus a small SHIFT=4 instance for the shift/floor behaviour.
module tb_systolic_output_drain;
    localparam int ROWS = 64;
    localparam int COLS = 64;
    localparam int OPW  = 48;
    localparam int OW   = 32;
    localparam int RW   = 6;
    localparam int ROWW = COLS * OW;
    localparam int EW   = ROWW + RW + 8;
    localparam int SR   = 4;
    localparam int SC   = 4;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       cd;
    logic [ROWS*COLS*OPW-1:0]   mat;
    logic [31:0]                cyc;
    logic                       busy, fd, derr;
    logic [31:0]                fcyc, satc;

    logic                       sh_cd;
    logic [SR*SC*OPW-1:0]       sh_mat;
    logic                       sh_busy, sh_fd, sh_derr;
    logic [31:0]                sh_fcyc, sh_satc;

    systolic_output_drain_if #(.ROWS(ROWS), .COLS(COLS), .OUT_WIDTH(OW)) dif ();
    systolic_output_drain_if #(.ROWS(SR), .COLS(SC), .OUT_WIDTH(OW)) sif ();

    systolic_output_drain #(.ROWS(ROWS), .COLS(COLS), .OP_WIDTH(OPW), .OUT_WIDTH(OW), .SHIFT(0)) dut (
        .clk(clk), .rst(rst), .compute_done(cd), .output_matrix(mat), .cycles_count(cyc),
        .drain(dif), .busy(busy), .frame_done(fd), .frame_cycles(fcyc), .sat_count(satc),
        .drop_err(derr)
    );

    systolic_output_drain #(.ROWS(SR), .COLS(SC), .OP_WIDTH(OPW), .OUT_WIDTH(OW), .SHIFT(4)) dut_sh (
        .clk(clk), .rst(rst), .compute_done(sh_cd), .output_matrix(sh_mat), .cycles_count(cyc),
        .drain(sif), .busy(sh_busy), .frame_done(sh_fd), .frame_cycles(sh_fcyc), .sat_count(sh_satc),
        .drop_err(sh_derr)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    int checks = 0;
    int errors = 0;

    // Model of the expected stream: each entry is {popcount, last, idx, row}.
    logic [EW-1:0] exp_q[$];
    int            m_sat;
    bit            m_drop;
    logic [31:0]   m_cycles;
    bit            m_fd;
    bit            m_prev;
    bit            just_rst;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] requant(input longint x, input int sh, output bit sat);
        longint v, mx, mn;
        v   = x >>> sh;
        mx  = (longint'(1) << (OW - 1)) - 1;
        mn  = -(longint'(1) << (OW - 1));
        sat = 1'b0;
        if (v > mx) begin
            sat = 1'b1;
            v   = mx;
        end else if (v < mn) begin
            sat = 1'b1;
            v   = mn;
        end
        return v[31:0];
    endfunction

    task automatic set_el(input int r, input int c, input longint v);
        mat[(r*COLS+c)*OPW +: OPW] = v[OPW-1:0];
    endtask

    task automatic rand_mat();
        longint v;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                v = {$urandom, $urandom};
                if ($urandom_range(0, 3) != 0) v = v >>> $urandom_range(17, 40);
                set_el(r, c, v);
            end
    endtask

    task automatic push_frame();
        logic [EW-1:0] e;
        bit            s;
        int            pop;
        for (int r = 0; r < ROWS; r++) begin
            e   = '0;
            pop = 0;
            for (int c = 0; c < COLS; c++) begin
                e[c*OW +: OW] = requant(longint'($signed(mat[(r*COLS+c)*OPW +: OPW])), 0, s);
                pop += int'(s);
            end
            e[ROWW +: RW]       = RW'(r);
            e[ROWW + RW]        = (r == ROWS - 1);
            e[ROWW + RW + 1 +: 7] = 7'(pop);
            exp_q.push_back(e);
        end
    endtask

    // Called at a falling edge once inputs for the coming rising edge are set.
    task automatic tick();
        logic [EW-1:0] f;
        bit            hs, fin;
        f = '0;
        chk("out_valid", dif.out_valid, exp_q.size() != 0);
        chk("busy", busy, exp_q.size() != 0);
        chk("frame_done", fd, m_fd);
        chk("sat_count", satc, 64'(m_sat));
        chk("drop_err", derr, m_drop);
        chk("frame_cycles", fcyc, m_cycles);
        if (just_rst) begin
            chk("rst_out_row_nonzero", dif.out_row != '0, 0);
            chk("rst_out_row_idx", dif.out_row_idx, 0);
            chk("rst_out_last", dif.out_last, 0);
            chk("rst_out_sat", dif.out_sat, 0);
        end
        if (exp_q.size() != 0) begin
            f = exp_q[0];
            chk("out_row_idx", dif.out_row_idx, f[ROWW +: RW]);
            chk("out_last", dif.out_last, f[ROWW + RW]);
            chk("out_sat", dif.out_sat, f[ROWW + RW + 1 +: 7] != 0);
            for (int c = 0; c < COLS; c++)
                chk($sformatf("row%0d_col%0d", f[ROWW +: RW], c), dif.out_row[c*OW +: OW], f[c*OW +: OW]);
        end
        hs  = (exp_q.size() != 0) && dif.out_ready;
        fin = hs && f[ROWW + RW];
        if (rst) begin
            exp_q.delete();
            m_sat    = 0;
            m_drop   = 0;
            m_cycles = '0;
            m_fd     = 0;
            m_prev   = 1;
            just_rst = 1;
        end else begin
            just_rst = 0;
            m_fd     = fin;
            if (hs) begin
                m_sat += int'(f[ROWW + RW + 1 +: 7]);
                void'(exp_q.pop_front());
            end
            if (cd && !m_prev) begin
                if (exp_q.size() == 0) begin
                    push_frame();
                    m_sat    = 0;
                    m_cycles = cyc;
                end else begin
                    m_drop = 1;
                end
            end
            m_prev = cd;
        end
        @(negedge clk);
    endtask

    task automatic cycle(input bit r, input bit c, input bit rdy);
        rst           = r;
        cd            = c;
        dif.out_ready = rdy;
        cyc           = $urandom;
        tick();
    endtask

    function automatic bit rnd_ready();
        return $urandom_range(0, 3) != 0;
    endfunction

    task automatic drain_all(input bit hold_cd, input bit random_ready);
        for (int k = 0; k < 1000 && exp_q.size() != 0; k++)
            cycle(0, hold_cd, random_ready ? rnd_ready() : 1'b1);
        for (int k = 0; k < 3; k++) cycle(0, hold_cd, 1);
    endtask

    function automatic int front_idx();
        logic [EW-1:0] f;
        if (exp_q.size() == 0) return -1;
        f = exp_q[0];
        return int'(f[ROWW +: RW]);
    endfunction

    initial begin
        bit s;
        rst = 1; cd = 0; mat = '0; cyc = '0; dif.out_ready = 0;
        sh_cd = 0; sh_mat = '0; sif.out_ready = 1;
        m_sat = 0; m_drop = 0; m_cycles = '0; m_fd = 0; m_prev = 1; just_rst = 1;
        @(negedge clk);
        cycle(1, 0, 0);
        cycle(1, 0, 0);

        // Identity frame, ready held high, compute_done held high throughout.
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) set_el(r, c, longint'(r * COLS + c));
        cycle(0, 0, 1);
        cycle(0, 1, 1);
        drain_all(1, 0);

        // Saturation pattern under random backpressure.
        cycle(0, 0, 1);
        mat = '0;
        set_el(0, 0, longint'(1) << 40);
        set_el(0, 1, -(longint'(1) << 40));
        set_el(5, 7, -5);
        cycle(0, 1, rnd_ready());
        drain_all(1, 1);
        chk("sat_frame_total", satc, 2);

        // Random frame; the input matrix changes while the frame streams.
        cycle(0, 0, 1);
        rand_mat();
        cycle(0, 1, rnd_ready());
        rand_mat();
        drain_all(0, 1);

        // Second edge mid-frame is dropped and the first frame is unaffected.
        rand_mat();
        cycle(0, 1, 1);
        for (int k = 0; k < 20; k++) cycle(0, 1, rnd_ready());
        cycle(0, 0, rnd_ready());
        rand_mat();
        cycle(0, 1, rnd_ready());
        drain_all(0, 1);
        chk("drop_err_sticky", derr, 1);

        // Back-to-back: new edge coincides with the final handshake.
        cycle(1, 0, 0);
        cycle(0, 0, 1);
        rand_mat();
        cycle(0, 1, 1);
        for (int k = 0; k < 200 && exp_q.size() > 1; k++) cycle(0, 0, 1);
        rand_mat();
        cycle(0, 1, 1);
        chk("b2b_valid_kept", dif.out_valid, 1);
        chk("b2b_frame_done", fd, 1);
        chk("b2b_row0", dif.out_row_idx, 0);
        drain_all(0, 1);
        chk("b2b_no_drop", derr, 0);

        // Reset at row 10 with compute_done held high across it.
        rand_mat();
        cycle(0, 1, 1);
        for (int k = 0; k < 500 && front_idx() != 10; k++) cycle(0, 1, rnd_ready());
        chk("reached_row10", front_idx(), 10);
        cycle(1, 1, 0);
        for (int k = 0; k < 3; k++) cycle(0, 1, 1);
        cycle(0, 0, 1);
        rand_mat();
        cycle(0, 1, 1);
        drain_all(0, 1);

        // SHIFT=4 instance: floor on negatives, plain shift, and saturation after the shift.
        sh_mat[0 +: OPW]          = OPW'(-17);
        sh_mat[OPW +: OPW]        = OPW'(32'h100);
        sh_mat[SC*OPW +: OPW]     = OPW'(longint'(1) << 40);
        sh_cd = 1;
        cycle(0, 0, 1);
        for (int k = 0; k < 8 && !sif.out_valid; k++) cycle(0, 0, 1);
        chk("sh_valid", sif.out_valid, 1);
        chk("sh_idx0", sif.out_row_idx, 0);
        chk("sh_neg17", sif.out_row[0 +: OW], requant(-17, 4, s));
        chk("sh_neg17_const", sif.out_row[0 +: OW], 32'hFFFF_FFFE);
        chk("sh_0x100", sif.out_row[OW +: OW], 32'h10);
        chk("sh_sat_row0", sif.out_sat, 0);
        cycle(0, 0, 1);
        chk("sh_idx1", sif.out_row_idx, 1);
        chk("sh_sat_val", sif.out_row[0 +: OW], 32'h7FFF_FFFF);
        chk("sh_sat_row1", sif.out_sat, 1);
        for (int k = 0; k < 4; k++) cycle(0, 0, 1);
        chk("sh_sat_count", sh_satc, 1);
        chk("sh_idle", sif.out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
